micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 The module SHALL have the ports below.
  - clk  in  1  sole clock; all state updates on its rising edge.
  - rst  in  1  reset; asynchronous, active-low.
  - flush_pipeline  in  1  synchronous flush from branch resolution.
  - dec_ready  in  1  decode stage ready indication.
  - idecode_cu_interface  in  92  decode bundle:
    - [31:0] instr
    - [39:32] micro_code_addr (0xFF = no operation)
    - [42:40] micro_code_cnt (number of follow-on micro-ops)
    - [74:43] micro_code (unused)
    - [82:75] instr_address_not_taken
    - [90:83] branch_instr_address
    - [91] branch_prediction_result
  - cu_ready  out  1  sequencer can accept a new instruction.
  - upc  out  8  microcode ROM address of the current micro-op.
  - uop_valid  out  1  upc holds a real micro-op this cycle.
  - uop_last  out  1  current micro-op is the final one of its instruction.
  - uop_index  out  3  position of the current micro-op within its instruction, 0-based.
  - instr_cu  out  32  latched instruction word.
  - instr_address_not_taken_cu  out  8  latched fall-through address.
  - branch_instr_address_cu  out  8  latched branch address.
  - branch_prediction_result_cu  out  1  latched prediction bit.

Function
REQ-002 The module SHALL have two states: ACCEPT and SEQ. All outputs SHALL be registered.
REQ-003 An instruction SHALL be accepted on a rising edge only when all of these hold: state==ACCEPT, cu_ready==1, dec_ready==1, flush_pipeline==0, micro_code_addr!=0xFF.
REQ-004 On acceptance, the module SHALL perform all of the following:
  - upc<=micro_code_addr
  - uop_valid<=1
  - uop_index<=0
  - rem<=micro_code_cnt
  - latch instr and the three branch fields
  - uop_last<=(micro_code_cnt==0)
  - if cnt!=0: state<=SEQ and cu_ready<=0; otherwise remain in ACCEPT with cu_ready=1.
REQ-005 In ACCEPT without acceptance (dec_ready=0 or micro_code_addr==0xFF), the module SHALL set upc<=0xFF, uop_valid<=0 and uop_last<=0, and SHALL hold the latched fields.
REQ-006 Each edge in SEQ SHALL perform: upc<=upc+1 (mod 256), uop_index<=uop_index+1, rem<=rem-1, uop_valid<=1.
REQ-007 In SEQ when rem==1, the next edge SHALL set uop_last<=1, state<=ACCEPT and cu_ready<=1.
REQ-008 An instruction with cnt=N SHALL produce exactly N+1 consecutive valid micro-ops at addresses addr..addr+N (8-bit wrap), one per cycle.
REQ-009 Back-to-back instructions SHALL issue without a bubble: the edge after a uop_last cycle may accept the next instruction.
REQ-010 flush_pipeline=1 SHALL take priority over all else, in any state. The next edge SHALL set:
  - state=ACCEPT, cu_ready=1
  - upc=0xFF, uop_valid=0, uop_last=0
  - uop_index=0, rem=0
REQ-011 A flush SHALL NOT accept the instruction presented in the same cycle.
REQ-012 The maximum cnt of 7 SHALL yield 8 micro-ops, with uop_index spanning 0..7 and no overflow.
REQ-013 While in SEQ, the decode-side inputs SHALL be ignored, except flush_pipeline.

Reset
REQ-014 While rst=0, the outputs SHALL be held as follows, independent of clk:
  - upc=0xFF
  - uop_valid=0, uop_last=0, uop_index=0
  - cu_ready=0
  - instr_cu=0 and all branch outputs=0
  - state=ACCEPT, rem=0
REQ-015 cu_ready SHALL rise on the first rising edge after rst deasserts. Acceptance SHALL be possible from the second edge onward.
REQ-016 Reset asserted mid-SEQ SHALL abort the sequence immediately. The following issue SHALL start from the next accepted instruction.

Verification
REQ-017 Directed scenarios:
  - Reset release, then addr=0x00, cnt=0 → one cycle of upc=0x00, uop_valid=1, uop_last=1; cu_ready stays 1.
  - addr=0x0A, cnt=2 → upc 0x0A, 0x0B, 0x0C on consecutive cycles with uop_index 0, 1, 2; uop_last only on 0x0C; cu_ready=0 during the first two.
  - addr=0x3A, cnt=4, then addr=0x31, cnt=0 presented continuously → 0x3A..0x3E then 0x31 with no invalid gap.
  - flush_pipeline pulsed during the second micro-op of cnt=2 → next cycle upc=0xFF, uop_valid=0, cu_ready=1; the remaining micro-op is never issued.
  - addr=0xFE, cnt=2 (forced) → upc 0xFE, 0xFF, 0x00 with uop_valid=1 throughout.
  - rst=0 asserted mid-sequence → outputs return to reset values without a clock edge; dec_ready=0 or addr=0xFF → uop_valid stays 0.

Source files
------------

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : micro_sequencer
// Purpose  : Expands one decoded instruction into 1..8 consecutive microcode
//            ROM addresses (upc), one per cycle, and latches the instruction
//            word and branch information alongside the sequence.
// Ports    : clk                   - clock, all state updates on rising edge
//            rst                   - asynchronous reset, active-low
//            flush_pipeline        - synchronous flush, highest priority
//            dec_ready             - decode stage presents an instruction
//            idecode_cu_interface  - 92-bit decode bundle
//            cu_ready              - sequencer can accept a new instruction
//            upc                   - microcode ROM address of current micro-op
//            uop_valid / uop_last  - micro-op valid / final micro-op
//            uop_index             - 0-based position within the instruction
//            instr_cu, instr_address_not_taken_cu, branch_instr_address_cu,
//            branch_prediction_result_cu - latched instruction fields
// Revision : 1.0 - initial release
// ============================================================================
module micro_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_pipeline,
  input  logic        dec_ready,
  input  logic [91:0] idecode_cu_interface,
  output logic        cu_ready,
  output logic [7:0]  upc,
  output logic        uop_valid,
  output logic        uop_last,
  output logic [2:0]  uop_index,
  output logic [31:0] instr_cu,
  output logic [7:0]  instr_address_not_taken_cu,
  output logic [7:0]  branch_instr_address_cu,
  output logic        branch_prediction_result_cu
);

  localparam logic [7:0] c_NOP_ADDR = 8'hFF;

  typedef enum logic [0:0] {
    ACCEPT = 1'b0,
    SEQ    = 1'b1
  } state_t;

  state_t     r_state;
  logic [2:0] r_rem;     // follow-on micro-ops still to issue

  logic [31:0] w_instr;
  logic [7:0]  w_mc_addr;
  logic [2:0]  w_mc_cnt;
  logic [7:0]  w_not_taken;
  logic [7:0]  w_branch_addr;
  logic        w_prediction;
  logic        w_accept;
  logic        w_unused_micro_code;

  assign w_instr       = idecode_cu_interface[31:0];
  assign w_mc_addr     = idecode_cu_interface[39:32];
  assign w_mc_cnt      = idecode_cu_interface[42:40];
  assign w_not_taken   = idecode_cu_interface[82:75];
  assign w_branch_addr = idecode_cu_interface[90:83];
  assign w_prediction  = idecode_cu_interface[91];

  // The micro_code payload is carried on the bundle but not consumed here.
  assign w_unused_micro_code = ^idecode_cu_interface[74:43];

  // cu_ready is low for the first edge after reset, so acceptance can only
  // happen from the second edge onward.
  assign w_accept = (r_state == ACCEPT) && cu_ready && dec_ready &&
                    !flush_pipeline && (w_mc_addr != c_NOP_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state                     <= ACCEPT;
      r_rem                       <= 3'd0;
      cu_ready                    <= 1'b0;
      upc                         <= c_NOP_ADDR;
      uop_valid                   <= 1'b0;
      uop_last                    <= 1'b0;
      uop_index                   <= 3'd0;
      instr_cu                    <= 32'd0;
      instr_address_not_taken_cu  <= 8'd0;
      branch_instr_address_cu     <= 8'd0;
      branch_prediction_result_cu <= 1'b0;
    end else if (flush_pipeline) begin
      // Flush wins in every state; latched instruction fields are kept.
      r_state   <= ACCEPT;
      r_rem     <= 3'd0;
      cu_ready  <= 1'b1;
      upc       <= c_NOP_ADDR;
      uop_valid <= 1'b0;
      uop_last  <= 1'b0;
      uop_index <= 3'd0;
    end else begin
      case (r_state)
        ACCEPT: begin
          if (w_accept) begin
            upc                         <= w_mc_addr;
            uop_valid                   <= 1'b1;
            uop_index                   <= 3'd0;
            r_rem                       <= w_mc_cnt;
            uop_last                    <= (w_mc_cnt == 3'd0);
            instr_cu                    <= w_instr;
            instr_address_not_taken_cu  <= w_not_taken;
            branch_instr_address_cu     <= w_branch_addr;
            branch_prediction_result_cu <= w_prediction;
            if (w_mc_cnt != 3'd0) begin
              r_state  <= SEQ;
              cu_ready <= 1'b0;
            end else begin
              r_state  <= ACCEPT;
              cu_ready <= 1'b1;
            end
          end else begin
            upc       <= c_NOP_ADDR;
            uop_valid <= 1'b0;
            uop_last  <= 1'b0;
            uop_index <= 3'd0;
            cu_ready  <= 1'b1;
          end
        end
        SEQ: begin
          // Decode-side inputs are ignored here; only flush can interrupt.
          upc       <= upc + 8'd1;
          uop_index <= uop_index + 3'd1;
          r_rem     <= r_rem - 3'd1;
          uop_valid <= 1'b1;
          if (r_rem == 3'd1) begin
            // Final micro-op: ready again so the next edge can accept
            // without a bubble.
            uop_last <= 1'b1;
            r_state  <= ACCEPT;
            cu_ready <= 1'b1;
          end else begin
            uop_last <= 1'b0;
          end
        end
        default: begin
          r_state  <= ACCEPT;
          cu_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_micro_sequencer
// Purpose  : Self-checking bench for micro_sequencer. A queue-based model of
//            pending micro-ops predicts every output cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_micro_sequencer;

  logic        clk;
  logic        rst;
  logic        flush_pipeline;
  logic        dec_ready;
  logic [91:0] idecode_cu_interface;
  logic        cu_ready;
  logic [7:0]  upc;
  logic        uop_valid;
  logic        uop_last;
  logic [2:0]  uop_index;
  logic [31:0] instr_cu;
  logic [7:0]  instr_address_not_taken_cu;
  logic [7:0]  branch_instr_address_cu;
  logic        branch_prediction_result_cu;

  int checks = 0;
  int errors = 0;

  micro_sequencer dut (
    .clk                         (clk),
    .rst                         (rst),
    .flush_pipeline              (flush_pipeline),
    .dec_ready                   (dec_ready),
    .idecode_cu_interface        (idecode_cu_interface),
    .cu_ready                    (cu_ready),
    .upc                         (upc),
    .uop_valid                   (uop_valid),
    .uop_last                    (uop_last),
    .uop_index                   (uop_index),
    .instr_cu                    (instr_cu),
    .instr_address_not_taken_cu  (instr_address_not_taken_cu),
    .branch_instr_address_cu     (branch_instr_address_cu),
    .branch_prediction_result_cu (branch_prediction_result_cu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] addr;
    logic [2:0] idx;
    logic       last;
  } uop_t;

  uop_t        pend[$];
  logic        m_ready;
  logic [7:0]  m_upc;
  logic        m_valid;
  logic        m_last;
  logic [2:0]  m_index;
  logic [48:0] m_latch;   // {instr, not_taken, branch_addr, prediction}

  function automatic logic [91:0] mk(logic [7:0] addr, logic [2:0] cnt);
    logic [91:0] b;
    b = {$urandom, $urandom, $urandom};
    b[39:32] = addr;
    b[42:40] = cnt;
    return b;
  endfunction

  function automatic logic [13:0] pk(logic r, logic v, logic l,
                                     logic [2:0] i, logic [7:0] u);
    return {r, v, l, i, u};
  endfunction

  // Observed status; uop_index only matters while a micro-op is valid.
  function automatic logic [13:0] obs(logic ev);
    return pk(cu_ready, uop_valid, uop_last, ev ? uop_index : 3'd0, upc);
  endfunction

  function automatic logic [48:0] obs_latch();
    return {instr_cu, instr_address_not_taken_cu, branch_instr_address_cu,
            branch_prediction_result_cu};
  endfunction

  task automatic model_reset();
    pend.delete();
    m_ready = 1'b0;
    m_upc   = 8'hFF;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_index = 3'd0;
    m_latch = '0;
  endtask

  // One clock edge: advance the model using the inputs seen at the edge,
  // then return 1 time unit after the edge.
  task automatic tick();
    uop_t        u;
    int          n;
    logic [7:0]  a;
    @(posedge clk);
    a = idecode_cu_interface[39:32];
    n = int'(idecode_cu_interface[42:40]);
    if (flush_pipeline) begin
      pend.delete();
      m_upc = 8'hFF; m_valid = 1'b0; m_last = 1'b0; m_index = 3'd0;
    end else if (pend.size() > 0) begin
      u = pend.pop_front();
      m_upc = u.addr; m_valid = 1'b1; m_last = u.last; m_index = u.idx;
    end else if (m_ready && dec_ready && a != 8'hFF) begin
      m_latch = {idecode_cu_interface[31:0], idecode_cu_interface[82:75],
                 idecode_cu_interface[90:83], idecode_cu_interface[91]};
      for (int k = 1; k <= n; k++) begin
        u.addr = a + 8'(k);
        u.idx  = 3'(k);
        u.last = (k == n);
        pend.push_back(u);
      end
      m_upc = a; m_valid = 1'b1; m_last = (n == 0); m_index = 3'd0;
    end else begin
      m_upc = 8'hFF; m_valid = 1'b0; m_last = 1'b0; m_index = 3'd0;
    end
    m_ready = (pend.size() == 0);
    #1;
  endtask

  task automatic idle_inputs();
    flush_pipeline       = 1'b0;
    dec_ready            = 1'b0;
    idecode_cu_interface = mk(8'hFF, 3'd0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    dec_ready            = 1'b1;
    idecode_cu_interface = mk(8'h20, 3'd0);
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs(1'b1) !== pk(0, 0, 0, 3'd0, 8'hFF)) begin
      errors++;
      $display("FAIL reset_status: got %h exp %h", obs(1'b1), pk(0, 0, 0, 3'd0, 8'hFF));
    end
    checks++;
    if (obs_latch() !== 49'd0) begin
      errors++;
      $display("FAIL reset_latch: got %h exp 0", obs_latch());
    end
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    // First edge: cu_ready rises, the valid instruction is not yet taken.
    tick();
    checks++;
    if (obs(1'b0) !== pk(1, 0, 0, 3'd0, 8'hFF)) begin
      errors++;
      $display("FAIL reset_first_edge: got %h exp %h", obs(1'b0), pk(1, 0, 0, 3'd0, 8'hFF));
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_single();
    logic [91:0] b;
    b = mk(8'h00, 3'd0);
    dec_ready = 1'b1;
    idecode_cu_interface = b;
    tick();
    checks++;
    if (obs(1'b1) !== pk(1, 1, 1, 3'd0, 8'h00)) begin
      errors++;
      $display("FAIL single_uop: got %h exp %h", obs(1'b1), pk(1, 1, 1, 3'd0, 8'h00));
    end
    checks++;
    if (obs_latch() !== {b[31:0], b[82:75], b[90:83], b[91]}) begin
      errors++;
      $display("FAIL single_latch: got %h exp %h", obs_latch(), {b[31:0], b[82:75], b[90:83], b[91]});
    end
    idle_inputs();
    tick();
    checks++;
    if (obs(1'b0) !== pk(1, 0, 0, 3'd0, 8'hFF)) begin
      errors++;
      $display("FAIL single_after: got %h exp %h", obs(1'b0), pk(1, 0, 0, 3'd0, 8'hFF));
    end
  endtask

  task automatic test_seq();
    logic [13:0] exp_v [3];
    exp_v[0] = pk(0, 1, 0, 3'd0, 8'h0A);
    exp_v[1] = pk(0, 1, 0, 3'd1, 8'h0B);
    exp_v[2] = pk(1, 1, 1, 3'd2, 8'h0C);
    dec_ready = 1'b1;
    idecode_cu_interface = mk(8'h0A, 3'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      // Decode inputs change while sequencing and must be ignored.
      if (i < 2) idecode_cu_interface = mk(8'h55, 3'd3);
      else idle_inputs();
      checks++;
      if (obs(1'b1) !== exp_v[i]) begin
        errors++;
        $display("FAIL seq_uop%0d: got %h exp %h", i, obs(1'b1), exp_v[i]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    dec_ready = 1'b1;
    idecode_cu_interface = mk(8'h3A, 3'd4);
    tick();
    idecode_cu_interface = mk(8'h31, 3'd0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      checks++;
      if (i < 5) begin
        if (obs(1'b1) !== pk(i == 4, 1, i == 4, 3'(i), 8'h3A + 8'(i))) begin
          errors++;
          $display("FAIL b2b_uop%0d: got %h exp %h", i, obs(1'b1), pk(i == 4, 1, i == 4, 3'(i), 8'h3A + 8'(i)));
        end
      end else begin
        if (obs(1'b1) !== pk(1, 1, 1, 3'd0, 8'h31)) begin
          errors++;
          $display("FAIL b2b_next: got %h exp %h", obs(1'b1), pk(1, 1, 1, 3'd0, 8'h31));
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    dec_ready = 1'b1;
    idecode_cu_interface = mk(8'h10, 3'd2);
    tick();
    tick();
    checks++;
    if (obs(1'b1) !== pk(0, 1, 0, 3'd1, 8'h11)) begin
      errors++;
      $display("FAIL flush_pre: got %h exp %h", obs(1'b1), pk(0, 1, 0, 3'd1, 8'h11));
    end
    flush_pipeline = 1'b1;
    idecode_cu_interface = mk(8'h40, 3'd0);
    tick();
    checks++;
    if (obs(1'b1) !== pk(1, 0, 0, 3'd0, 8'hFF) || uop_index !== 3'd0) begin
      errors++;
      $display("FAIL flush_cycle: got %h exp %h", obs(1'b1), pk(1, 0, 0, 3'd0, 8'hFF));
    end
    // Flush in ACCEPT with a valid instruction must not accept it either.
    tick();
    checks++;
    if (obs(1'b0) !== pk(1, 0, 0, 3'd0, 8'hFF)) begin
      errors++;
      $display("FAIL flush_no_accept: got %h exp %h", obs(1'b0), pk(1, 0, 0, 3'd0, 8'hFF));
    end
    idle_inputs();
    tick();
    checks++;
    if (uop_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_resume: got %b exp 0", uop_valid);
    end
  endtask

  task automatic test_wrap_and_max();
    dec_ready = 1'b1;
    idecode_cu_interface = mk(8'hFE, 3'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      idle_inputs();
      checks++;
      if (obs(1'b1) !== pk(i == 2, 1, i == 2, 3'(i), 8'hFE + 8'(i))) begin
        errors++;
        $display("FAIL wrap_uop%0d: got %h exp %h", i, obs(1'b1), pk(i == 2, 1, i == 2, 3'(i), 8'hFE + 8'(i)));
      end
    end
    tick();
    dec_ready = 1'b1;
    idecode_cu_interface = mk(8'hF9, 3'd7);
    for (int i = 0; i < 8; i++) begin
      tick();
      idle_inputs();
      checks++;
      if (obs(1'b1) !== pk(i == 7, 1, i == 7, 3'(i), 8'hF9 + 8'(i))) begin
        errors++;
        $display("FAIL max_uop%0d: got %h exp %h", i, obs(1'b1), pk(i == 7, 1, i == 7, 3'(i), 8'hF9 + 8'(i)));
      end
    end
    tick();
    checks++;
    if (uop_valid !== 1'b0) begin
      errors++;
      $display("FAIL max_end: got %b exp 0", uop_valid);
    end
  endtask

  task automatic test_nop();
    dec_ready = 1'b1;
    idecode_cu_interface = mk(8'hFF, 3'd3);
    tick();
    checks++;
    if (uop_valid !== 1'b0 || cu_ready !== 1'b1) begin
      errors++;
      $display("FAIL nop_addr: got valid=%b ready=%b exp valid=0 ready=1", uop_valid, cu_ready);
    end
    dec_ready = 1'b0;
    idecode_cu_interface = mk(8'h22, 3'd1);
    tick();
    checks++;
    if (uop_valid !== 1'b0 || upc !== 8'hFF) begin
      errors++;
      $display("FAIL nop_not_ready: got valid=%b upc=%h exp valid=0 upc=ff", uop_valid, upc);
    end
  endtask

  task automatic test_reset_mid_seq();
    dec_ready = 1'b1;
    idecode_cu_interface = mk(8'h60, 3'd5);
    tick();
    idle_inputs();
    tick();
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs(1'b1) !== pk(0, 0, 0, 3'd0, 8'hFF) || obs_latch() !== 49'd0) begin
      errors++;
      $display("FAIL reset_mid_seq: got %h exp %h", obs(1'b1), pk(0, 0, 0, 3'd0, 8'hFF));
    end
    @(posedge clk);
    #2 rst = 1'b1;
    tick();
    dec_ready = 1'b1;
    idecode_cu_interface = mk(8'h70, 3'd1);
    tick();
    idle_inputs();
    checks++;
    if (obs(1'b1) !== pk(0, 1, 0, 3'd0, 8'h70)) begin
      errors++;
      $display("FAIL reset_restart: got %h exp %h", obs(1'b1), pk(0, 1, 0, 3'd0, 8'h70));
    end
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int c = 0; c < 600; c++) begin
      flush_pipeline = ($urandom_range(0, 11) == 0);
      dec_ready      = ($urandom_range(0, 3) != 0);
      a              = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      idecode_cu_interface = mk(a, 3'($urandom));
      tick();
      checks++;
      if (obs(m_valid) !== pk(m_ready, m_valid, m_last, m_index, m_upc)) begin
        errors++;
        $display("FAIL rand_status c=%0d: got %h exp %h", c, obs(m_valid), pk(m_ready, m_valid, m_last, m_index, m_upc));
      end
      checks++;
      if (obs_latch() !== m_latch) begin
        errors++;
        $display("FAIL rand_latch c=%0d: got %h exp %h", c, obs_latch(), m_latch);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_single();
    test_seq();
    test_back_to_back();
    test_flush();
    test_wrap_and_max();
    test_nop();
    test_reset_mid_seq();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
